// File: rtl/seq_alu_unit_if.sv
// Request/result bundle between the control unit (master) and seq_alu_unit (slave).
// WIDTH must match the WIDTH of the seq_alu_unit instance it connects to.
interface seq_alu_unit_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             Start;
  logic [4:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [SHW-1:0]   ShAmt;
  logic             WF;
  logic [WIDTH-1:0] ALUOut;
  logic [WIDTH-1:0] ALUOutHi;
  logic [3:0]       FlagsOut;
  logic             Busy;
  logic             Done;
  logic             Err;

  modport master (
    output Start, Op, A, B, ShAmt, WF,
    input  ALUOut, ALUOutHi, FlagsOut, Busy, Done, Err
  );

  modport slave (
    input  Start, Op, A, B, ShAmt, WF,
    output ALUOut, ALUOutHi, FlagsOut, Busy, Done, Err
  );
endinterface

// File: rtl/seq_alu_unit.sv
// Multi-cycle ALU with Start/Busy/Done handshake, iterative shifts/rotates and registered flags.
// Optional iterative unsigned multiplier (Op 16) compiled in when ALU_MUL_EN is defined.
module seq_alu_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic          Clock,
  input  logic          Reset,
  seq_alu_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_PASSA = 5'd0;
  localparam logic [4:0] OP_PASSB = 5'd1;
  localparam logic [4:0] OP_NOTA  = 5'd2;
  localparam logic [4:0] OP_NOTB  = 5'd3;
  localparam logic [4:0] OP_ADD   = 5'd4;
  localparam logic [4:0] OP_ADC   = 5'd5;
  localparam logic [4:0] OP_SUB   = 5'd6;
  localparam logic [4:0] OP_AND   = 5'd7;
  localparam logic [4:0] OP_OR    = 5'd8;
  localparam logic [4:0] OP_XOR   = 5'd9;
  localparam logic [4:0] OP_NAND  = 5'd10;
  localparam logic [4:0] OP_LSL   = 5'd11;
  localparam logic [4:0] OP_LSR   = 5'd12;
  localparam logic [4:0] OP_ASR   = 5'd13;
  localparam logic [4:0] OP_CSL   = 5'd14;
  localparam logic [4:0] OP_CSR   = 5'd15;
  localparam logic [4:0] OP_MUL   = 5'd16;

  // Bit positions inside FlagsOut = {Z,C,N,O}.
  localparam int FZ = 3;
  localparam int FC = 2;
  localparam int FN = 1;
  localparam int FO = 0;

  localparam logic [3:0] M_ZN   = 4'b1010;
  localparam logic [3:0] M_ZC   = 4'b1100;
  localparam logic [3:0] M_ZCN  = 4'b1110;
  localparam logic [3:0] M_ALL  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  logic             wf_q, wf_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] shifted;
  logic [3:0]       fval;
  logic [3:0]       fmask;
  logic             upd;
  logic             fwe;
  logic             step_out;
  logic             fill;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] alu_hi_q, alu_hi_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] res_hi;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d  = state_q;
    alu_out_d = alu_out_q;
    flags_d  = flags_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    wf_d     = wf_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    sum      = '0;
    res      = '0;
    shifted  = '0;
    fval     = '0;
    fmask    = '0;
    upd      = 1'b0;
    fwe      = 1'b0;
    step_out = 1'b0;
    fill     = 1'b0;
`ifdef ALU_MUL_EN
    alu_hi_d = alu_hi_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    msum     = '0;
    res_hi   = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          // Default: the op completes at this edge; multi-cycle ops override below.
          err_d  = 1'b0;
          op_d   = bus.Op;
          wf_d   = bus.WF;
          done_d = 1'b1;
          upd    = 1'b1;
          fwe    = bus.WF;
          fmask  = M_ZN;
          case (bus.Op)
            OP_PASSA: res = bus.A;
            OP_PASSB: res = bus.B;
            OP_NOTA:  res = ~bus.A;
            OP_NOTB:  res = ~bus.B;
            OP_ADD, OP_ADC, OP_SUB: begin
              if (bus.Op == OP_SUB) begin
                sum = {1'b0, bus.A} - {1'b0, bus.B};
              end else begin
                sum = {1'b0, bus.A} + {1'b0, bus.B};
                if (bus.Op == OP_ADC) sum = sum + {{WIDTH{1'b0}}, flags_q[FC]};
              end
              res       = sum[WIDTH-1:0];
              fmask     = M_ALL;
              // Bit WIDTH is the carry for add and the borrow (A<B) for subtract.
              fval[FC]  = sum[WIDTH];
              if (bus.Op == OP_SUB)
                fval[FO] = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (res[WIDTH-1] != bus.A[WIDTH-1]);
              else
                fval[FO] = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND:  res = bus.A & bus.B;
            OP_OR:   res = bus.A | bus.B;
            OP_XOR:  res = bus.A ^ bus.B;
            OP_NAND: res = ~(bus.A & bus.B);
            OP_LSL, OP_LSR, OP_ASR, OP_CSL, OP_CSR: begin
              res = bus.A;
              if (bus.ShAmt != '0) begin
                state_d = S_SHIFT;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                upd     = 1'b0;
                work_d  = bus.A;
                cnt_d   = CW'(bus.ShAmt);
                carry_d = flags_q[FC];
              end
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
              state_d = S_MUL;
              busy_d  = 1'b1;
              done_d  = 1'b0;
              upd     = 1'b0;
              work_d  = bus.B;
              mcand_d = bus.A;
              acc_d   = '0;
              cnt_d   = CW'(WIDTH);
            end
`else
            OP_MUL: begin
              upd   = 1'b0;
              err_d = 1'b1;
            end
`endif
            default: begin
              upd   = 1'b0;
              err_d = 1'b1;
            end
          endcase
        end
      end

      S_SHIFT: begin
        if (op_q == OP_LSL || op_q == OP_CSL) begin
          step_out = work_q[WIDTH-1];
          fill     = (op_q == OP_CSL) ? carry_q : 1'b0;
          shifted  = {work_q[WIDTH-2:0], fill};
        end else begin
          step_out = work_q[0];
          if (op_q == OP_ASR)      fill = work_q[WIDTH-1];
          else if (op_q == OP_CSR) fill = carry_q;
          else                     fill = 1'b0;
          shifted  = {fill, work_q[WIDTH-1:1]};
        end
        work_d  = shifted;
        carry_d = step_out;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          upd      = 1'b1;
          fwe      = wf_q;
          res      = shifted;
          fval[FC] = step_out;
          fmask    = (op_q == OP_ASR) ? M_ZC : M_ZCN;
        end
      end

`ifdef ALU_MUL_EN
      S_MUL: begin
        // Shift-add: conditionally add the multiplicand to the high half, then shift
        // the whole {acc, work} pair right; work gradually fills with the low product.
        msum   = work_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};
        acc_d  = msum[WIDTH:1];
        work_d = {msum[0], work_q[WIDTH-1:1]};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          upd      = 1'b1;
          fwe      = wf_q;
          res      = work_d;
          res_hi   = acc_d;
          fmask    = M_ALL;
          fval[FC] = (acc_d != '0);
          fval[FO] = 1'b0;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (upd) begin
      alu_out_d = res;
`ifdef ALU_MUL_EN
      alu_hi_d  = res_hi;
      fval[FZ]  = (res == '0) && (res_hi == '0);
      fval[FN]  = (state_q == S_MUL) ? res_hi[WIDTH-1] : res[WIDTH-1];
`else
      fval[FZ]  = (res == '0);
      fval[FN]  = res[WIDTH-1];
`endif
      if (fwe) flags_d = (flags_q & ~fmask) | (fval & fmask);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      alu_out_q <= '0;
      flags_q   <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      wf_q      <= 1'b0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      flags_q   <= flags_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      wf_q      <= wf_d;
      carry_q   <= carry_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      alu_hi_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
    end else begin
      alu_hi_q <= alu_hi_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
    end
  end

  assign bus.ALUOutHi = alu_hi_q;
`else
  assign bus.ALUOutHi = '0;
`endif

  assign bus.ALUOut   = alu_out_q;
  assign bus.FlagsOut = flags_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Err      = err_q;
endmodule
